// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer
//
// Folded adder tree. A vector of NUM_WORDS words is accepted in a single
// valid/ready handshake. One registered layer of pairwise adders is then
// reused once per clock until a single word is left. That word is the sum.
//
// Ports:
//   clk        clock, rising-edge active
//   arst       asynchronous active-high reset
//   in_words   operand vector, word i = in_words[(i+1)*IN_BITS-1 : i*IN_BITS]
//   in_valid   operand vector valid
//   in_ready   vector can be accepted this cycle (IDLE, or DONE while the
//              result is being consumed)
//   out_sum    reduction result, held stable while out_valid is high
//   out_valid  out_sum valid
//   out_ready  consumer accepts out_sum
//   busy       reduction passes in progress
//
// Latency from the accept edge to out_valid is ceil(log2(NUM_WORDS)) edges.
// With NUM_WORDS == 1 the result is registered at the accept edge itself.

module adder_tree_sequencer #(
    parameter int NUM_WORDS = 8,
    parameter int IN_BITS   = 16,
    parameter int OUT_BITS  = 19,
    parameter int SIGN_EXT  = 1
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [NUM_WORDS*IN_BITS-1:0]  in_words,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_BITS-1:0]           out_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int CNT_W = $clog2(NUM_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_r;
    logic [OUT_BITS-1:0] work_r      [NUM_WORDS];
    logic [OUT_BITS-1:0] next_work_s [NUM_WORDS];
    logic [OUT_BITS-1:0] load_work_s [NUM_WORDS];
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    half_s;
    logic [CNT_W-1:0]    next_cnt_s;
    logic [OUT_BITS-1:0] out_sum_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                in_ready_s;
    logic                accept_s;

    // Widen one input word to the internal width, signed or unsigned.
    function automatic logic [OUT_BITS-1:0] extend_word(input logic [IN_BITS-1:0] word);
        logic [OUT_BITS-1:0] ext;
        if (SIGN_EXT != 0) begin
            ext = OUT_BITS'($signed(word));
        end else begin
            ext = OUT_BITS'(word);
        end
        return ext;
    endfunction

    // Readiness depends only on state and the consumer, never on in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if ((state_r == ST_DONE) && out_ready) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid & in_ready_s;

    // Live word count after this pass: ceil(cnt/2).
    assign half_s     = cnt_r >> 1;
    assign next_cnt_s = half_s + CNT_W'(cnt_r[0]);

    // One pairwise-add layer. Slot j takes the sum of slots 2j and 2j+1 while
    // pairs remain. When the count is odd, the unpaired last word (index
    // cnt-1 == 2*half) moves down to slot half. All other slots hold.
    for (genvar j = 0; j < NUM_WORDS; j++) begin : g_layer
        assign load_work_s[j] = extend_word(in_words[j*IN_BITS +: IN_BITS]);

        if (2*j + 1 < NUM_WORDS) begin : g_pair
            assign next_work_s[j] =
                (CNT_W'(j) < half_s)                  ? work_r[2*j] + work_r[2*j+1] :
                ((CNT_W'(j) == half_s) && cnt_r[0])   ? work_r[2*j] :
                                                        work_r[j];
        end else if (2*j < NUM_WORDS) begin : g_carry
            assign next_work_s[j] =
                ((CNT_W'(j) == half_s) && cnt_r[0]) ? work_r[2*j] : work_r[j];
        end else begin : g_hold
            assign next_work_s[j] = work_r[j];
        end
    end

    // Sequencer state, work registers and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            for (int i = 0; i < NUM_WORDS; i++) begin
                work_r[i] <= {OUT_BITS{1'b0}};
            end
            out_sum_r   <= {OUT_BITS{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            // Accepting from DONE also consumes the pending result.
            work_r <= load_work_s;
            cnt_r  <= CNT_FULL;
            if (NUM_WORDS == 1) begin
                out_sum_r   <= load_work_s[0];
                out_valid_r <= 1'b1;
                busy_r      <= 1'b0;
                state_r     <= ST_DONE;
            end else begin
                out_valid_r <= 1'b0;
                busy_r      <= 1'b1;
                state_r     <= ST_REDUCE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                ST_REDUCE: begin
                    work_r <= next_work_s;
                    cnt_r  <= next_cnt_s;
                    if (next_cnt_s == CNT_ONE) begin
                        out_sum_r   <= next_work_s[0];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_sum   = out_sum_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule
